// File: rtl/fir_pwm_dac.sv
// rtl/fir_pwm_dac.sv - double-buffered PWM DAC fed by the FIR sample stream (option: FIR_PWM_DITHER_EN)
module fir_pwm_dac #(
  parameter int N_BITS   = 16,
  parameter int PWM_BITS = 4
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic signed [N_BITS-1:0] sample,
  input  logic                     sample_ready,
  output logic                     pwm_out,
  output logic                     sample_taken,
  output logic                     overrun
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [N_BITS-1:0]   pending_q, pending_d;
  logic                pending_valid_q, pending_valid_d;
  logic                ready_q, ready_d;
  logic                pwm_q, pwm_d;
  logic                taken_q, taken_d;
  logic                overrun_q, overrun_d;

  logic                rise;
  logic                boundary;
  logic                load;

`ifdef FIR_PWM_DITHER_EN
  logic [N_BITS-1:0]          held_q, held_d;
  logic [N_BITS-PWM_BITS-1:0] resid_q, resid_d;
  logic [N_BITS-1:0]          dither_src;
  logic [N_BITS:0]            dither_sum;
`endif

  // Strobe edge detect, period boundary / load decision, capture buffer and overrun
  always_comb begin
    rise     = sample_ready & ~ready_q;
    ready_d  = sample_ready;
    // IDLE has a boundary only when something is waiting to start the first period
    boundary = (state_q == IDLE) ? pending_valid_q : (cnt_q == CNT_MAX);
    load     = boundary & pending_valid_q;

    // Offset-binary conversion: inverting the MSB adds 2^(N_BITS-1)
    pending_d       = rise ? {~sample[N_BITS-1], sample[N_BITS-2:0]} : pending_q;
    // A capture coinciding with a load refills the buffer, so valid stays set
    pending_valid_d = rise | (pending_valid_q & ~load);
    overrun_d       = overrun_q | (rise & pending_valid_q & ~load);
    taken_d         = load;
  end

  // Period counter, run/idle state and the registered PWM compare
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pwm_d   = 1'b0;
    if (state_q == IDLE) begin
      if (pending_valid_q) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = CNT_MAX;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      pwm_d = (cnt_q < duty_q);
    end
  end

`ifdef FIR_PWM_DITHER_EN
  // Error-feedback duty: every boundary re-quantises held sample plus carried residual
  always_comb begin
    held_d     = load ? pending_q : held_q;
    dither_src = load ? pending_q : held_q;
    dither_sum = {1'b0, dither_src} + {{(PWM_BITS+1){1'b0}}, resid_q};
    duty_d     = duty_q;
    resid_d    = resid_q;
    if (boundary) begin
      if (dither_sum[N_BITS]) begin
        duty_d  = CNT_MAX;
        resid_d = '0;
      end else begin
        duty_d  = dither_sum[N_BITS-1 -: PWM_BITS];
        resid_d = dither_sum[N_BITS-PWM_BITS-1:0];
      end
    end
  end
`else
  // Plain truncation: duty only moves when a pending sample is loaded
  always_comb begin
    duty_d = load ? pending_q[N_BITS-1 -: PWM_BITS] : duty_q;
  end
`endif

  // State registers with synchronous active-low reset
  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= CNT_MAX;
      duty_q          <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      ready_q         <= 1'b0;
      pwm_q           <= 1'b0;
      taken_q         <= 1'b0;
      overrun_q       <= 1'b0;
`ifdef FIR_PWM_DITHER_EN
      held_q          <= '0;
      resid_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      duty_q          <= duty_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      ready_q         <= ready_d;
      pwm_q           <= pwm_d;
      taken_q         <= taken_d;
      overrun_q       <= overrun_d;
`ifdef FIR_PWM_DITHER_EN
      held_q          <= held_d;
      resid_q         <= resid_d;
`endif
    end
  end

  assign pwm_out      = pwm_q;
  assign sample_taken = taken_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fir_pwm_dac.sv
// tb/tb_fir_pwm_dac.sv - directed self-checking bench for fir_pwm_dac (FIR_PWM_DITHER_EN selects dither checks)
module tb_fir_pwm_dac;

  logic               ck = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] sample = '0;
  logic               sample_ready = 1'b0;
  logic               pwm_out;
  logic               sample_taken;
  logic               overrun;

  int checks = 0;
  int failures = 0;

  fir_pwm_dac #(.N_BITS(16), .PWM_BITS(4)) dut (
    .ck           (ck),
    .rst          (rst),
    .sample       (sample),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .sample_taken (sample_taken),
    .overrun      (overrun)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic signed [15:0] smp;
    int                 duty;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int mask_of(input int d);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < d; i++) m[i] = 1'b1;
    return int'(m);
  endfunction

  task automatic strobe(input logic signed [15:0] s);
    sample       = s;
    sample_ready = 1'b1;
    @(negedge ck);
    sample_ready = 1'b0;
  endtask

  task automatic wait_taken(output int highs, output int ok);
    highs = 0;
    ok    = 0;
    for (int i = 0; i < 64 && ok == 0; i++) begin
      @(negedge ck);
      if (sample_taken) ok = 1;
      else highs += int'(pwm_out);
    end
  endtask

  task automatic capture(output int pat);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge ck);
      p[i] = pwm_out;
    end
    pat = int'(p);
  endtask

  task automatic reset_test();
    int bad;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_ready = (i % 2 == 0);
      @(negedge ck);
    end
    sample_ready = 1'b0;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (pwm_out || sample_taken || overrun) bad++;
    end
    chk("reset_idle_outputs_nonzero_cycles", bad, 0);
  endtask

  initial begin
    int h, ok, pat, prev, bad, pulses;

    vecs[0] = '{16'sd0,      8};
    vecs[1] = '{-16'sd32768, 0};
    vecs[2] = '{16'sd32767,  15};
    vecs[3] = '{16'sd10000,  10};
    vecs[4] = '{-16'sd10000, 5};
    vecs[5] = '{-16'sd1,     7};
    vecs[6] = '{16'sd1,      8};
    vecs[7] = '{16'sd4096,   9};
    vecs[8] = '{16'sd16383,  11};

    @(negedge ck);
    reset_test();

`ifdef FIR_PWM_DITHER_EN
    strobe(16'sd2048);
    wait_taken(h, ok);
    chk("dither_taken", ok, 1);
    for (int p = 0; p < 4; p++) begin
      capture(pat);
      chk($sformatf("dither_period%0d", p), pat, mask_of((p % 2 == 0) ? 8 : 9));
    end
    chk("dither_overrun", int'(overrun), 0);
`else
    // Table: each new sample appears only at the next period boundary
    prev = 0;
    foreach (vecs[i]) begin
      strobe(vecs[i].smp);
      wait_taken(h, ok);
      chk($sformatf("vec%0d_taken", i), ok, 1);
      chk($sformatf("vec%0d_old_duty_highs", i), h, (prev == 0) ? 0 : prev - 1);
      capture(pat);
      chk($sformatf("vec%0d_pattern", i), pat, mask_of(vecs[i].duty));
      prev = vecs[i].duty;
    end
    chk("table_no_overrun", int'(overrun), 0);

    // Capture on the very edge of a load: old pending loads, new stays pending, no overrun
    strobe(-16'sd32768);
    repeat (14) @(negedge ck);
    strobe(16'sd32767);
    chk("simul_load_taken", int'(sample_taken), 1);
    chk("simul_no_overrun", int'(overrun), 0);
    capture(pat);
    chk("simul_first_pattern", pat, mask_of(0));
    chk("simul_second_taken", int'(sample_taken), 1);
    capture(pat);
    chk("simul_second_pattern", pat, mask_of(15));
    chk("simul_overrun_still0", int'(overrun), 0);

    // Two captures inside one period: second overwrites, overrun sticks
    strobe(16'sd10000);
    @(negedge ck);
    strobe(-16'sd10000);
    wait_taken(h, ok);
    chk("ovr_taken", ok, 1);
    capture(pat);
    chk("ovr_pattern", pat, mask_of(5));
    chk("ovr_flag", int'(overrun), 1);
    repeat (20) @(negedge ck);
    chk("ovr_sticky", int'(overrun), 1);
    chk("mid_reset_pre_pwm", int'(pwm_out), 1);

    // Reset in the middle of a period clears everything on the next edge
    rst = 1'b0;
    @(negedge ck);
    chk("mid_reset_pwm", int'(pwm_out), 0);
    chk("mid_reset_taken", int'(sample_taken), 0);
    chk("mid_reset_overrun", int'(overrun), 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      if (pwm_out || sample_taken) bad++;
    end
    chk("post_reset_idle", bad, 0);

    // Strobe held high five cycles captures exactly once
    sample = 16'sd0;
    sample_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 65; i++) begin
      if (i == 5) sample_ready = 1'b0;
      @(negedge ck);
      pulses += int'(sample_taken);
    end
    chk("held_strobe_pulses", pulses, 1);
    chk("held_strobe_overrun", int'(overrun), 0);
    capture(pat);
    chk("held_strobe_duty8_highs", $countones(pat[15:0]), 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
